// File: rtl/ifu.sv
// rtl/ifu.sv - instruction fetch unit: sequential paired fetch with a 2-entry fetch buffer
package ifu_pkg;
  typedef struct packed {
    logic        i0_valid;
    logic [31:0] i0_inst;
    logic        i1_valid;
    logic [31:0] i1_inst;
    logic [31:0] addr;
  } inst_pkt_t;
endpackage

module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_dec,
  input  logic        dec_ready,
  input  logic        flush_ifu,
  input  logic [31:0] redirect_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [63:0] imem_rdata,
  output inst_pkt_t   ifu_inst_p
);

  logic [63:0] buf_data [2];
  logic [31:0] buf_addr [2];
  logic [1:0]  buf_skip;
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic        inflight;
  logic [31:0] inflight_addr;
  logic [31:0] fetch_pc;
  logic        skip_pending;

  logic        head_valid;
  logic        accept;
  logic        push;
  logic        req_core;
  logic [2:0]  occupancy;

  assign head_valid = (count != 2'd0);

  always_comb begin
    ifu_inst_p.i0_valid = head_valid && !buf_skip[rd_ptr];
    ifu_inst_p.i0_inst  = buf_data[rd_ptr][31:0];
    ifu_inst_p.i1_valid = head_valid;
    ifu_inst_p.i1_inst  = buf_data[rd_ptr][63:32];
    ifu_inst_p.addr     = buf_addr[rd_ptr];
  end

  assign accept = dec_ready && !stall_dec && (ifu_inst_p.i0_valid || ifu_inst_p.i1_valid);
  assign push   = imem_rvalid && inflight && !flush_ifu;

  // Credit check counts the response already in flight so the buffer can never overflow.
  assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, accept};
  assign req_core  = !flush_ifu && (occupancy < 3'd2);
  assign imem_req  = rst_n && req_core;
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr_ptr] <= imem_rdata;
      buf_addr[wr_ptr] <= inflight_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_skip      <= 2'b00;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      count         <= 2'd0;
      inflight      <= 1'b0;
      inflight_addr <= 32'd0;
      fetch_pc      <= RESET_ADDR;
      skip_pending  <= 1'b0;
    end else if (flush_ifu) begin
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      count        <= 2'd0;
      inflight     <= 1'b0;
      fetch_pc     <= {redirect_addr[31:3], 3'b000};
      skip_pending <= redirect_addr[2];
    end else begin
      inflight <= req_core;
      if (req_core) begin
        fetch_pc      <= fetch_pc + 32'd8;
        inflight_addr <= fetch_pc;
      end
      if (push) begin
        buf_skip[wr_ptr] <= skip_pending;
        wr_ptr           <= ~wr_ptr;
        skip_pending     <= 1'b0;
      end
      if (accept) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, accept};
    end
  end

endmodule

// File: tb/tb_ifu.sv
// tb/tb_ifu.sv - randomized scoreboard bench for ifu against a sequential-fetch reference model
module tb_ifu;
  import ifu_pkg::*;

  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_dec = 1'b0;
  logic        dec_ready = 1'b0;
  logic        flush_ifu = 1'b0;
  logic [31:0] redirect_addr = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [63:0] imem_rdata = 64'd0;
  inst_pkt_t   ifu_inst_p;

  ifu #(.RESET_ADDR(RESET_ADDR)) dut (
    .clk(clk), .rst_n(rst_n), .stall_dec(stall_dec), .dec_ready(dec_ready),
    .flush_ifu(flush_ifu), .redirect_addr(redirect_addr),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ifu_inst_p(ifu_inst_p)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        i0v;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_pc = RESET_ADDR;
  logic        model_skip = 1'b0;
  logic [31:0] req_pc = RESET_ADDR;
  logic        force_stray = 1'b0;
  int          checks = 0;
  int          failures = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Sequential fetch from the last redirect: the expected stream is simply model_pc, +8, +8, ...
  task automatic refill();
    exp_t e;
    while (exp_q.size() < 4) begin
      e.addr = model_pc;
      e.i0v  = !model_skip;
      exp_q.push_back(e);
      model_pc   = model_pc + 32'd8;
      model_skip = 1'b0;
    end
  endtask

  task automatic model_restart(input logic [31:0] a);
    exp_q.delete();
    model_pc   = {a[31:3], 3'b000};
    model_skip = a[2];
    req_pc     = {a[31:3], 3'b000};
    refill();
  endtask

  // Memory: answers each request exactly one cycle later, plus stray rvalids when idle.
  initial begin
    logic        prev_req;
    logic [31:0] prev_addr;
    forever begin
      @(negedge clk);
      prev_req  = rst_n && imem_req;
      prev_addr = imem_addr;
      @(posedge clk);
      #1;
      if (prev_req) begin
        imem_rvalid = 1'b1;
        imem_rdata  = {mem_word(prev_addr + 32'd4), mem_word(prev_addr)};
      end else if (force_stray || $urandom_range(3) == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = {$urandom, $urandom};
      end else begin
        imem_rvalid = 1'b0;
      end
      force_stray = 1'b0;
    end
  end

  // Monitor: pops the scoreboard on every accept and tracks the request address stream.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if ((ifu_inst_p.i0_valid || ifu_inst_p.i1_valid) && dec_ready && !stall_dec) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_pkt", {32'd0, ifu_inst_p.addr}, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("pkt_addr", {32'd0, ifu_inst_p.addr}, {32'd0, e.addr});
            chk("pkt_i0_valid", {63'd0, ifu_inst_p.i0_valid}, {63'd0, e.i0v});
            chk("pkt_i1_valid", {63'd0, ifu_inst_p.i1_valid}, 64'd1);
            if (e.i0v) chk("pkt_i0_inst", {32'd0, ifu_inst_p.i0_inst}, {32'd0, mem_word(e.addr)});
            chk("pkt_i1_inst", {32'd0, ifu_inst_p.i1_inst}, {32'd0, mem_word(e.addr + 32'd4)});
          end
        end
        if (flush_ifu) begin
          chk("req_in_flush", {63'd0, imem_req}, 64'd0);
          model_restart(redirect_addr);
        end else if (imem_req) begin
          chk("req_addr", {32'd0, imem_addr}, {32'd0, req_pc});
          req_pc = req_pc + 32'd8;
        end
        refill();
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_to(input logic [31:0] a);
    step();
    flush_ifu     = 1'b1;
    redirect_addr = a;
    step();
    flush_ifu = 1'b0;
  endtask

  task automatic hold_phase(input logic rdy, input logic stl, input string name);
    inst_pkt_t snap;
    step();
    dec_ready = rdy;
    stall_dec = stl;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) snap = ifu_inst_p;
      chk({name, "_req_off"}, {63'd0, imem_req}, 64'd0);
      if (i > 0) chk({name, "_head_held"}, {63'd0, ifu_inst_p == snap}, 64'd1);
      chk({name, "_head_valid"}, {63'd0, ifu_inst_p.i1_valid}, 64'd1);
      step();
    end
    dec_ready = 1'b1;
    stall_dec = 1'b0;
  endtask

  task automatic random_run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      dec_ready     = ($urandom_range(3) != 0);
      stall_dec     = ($urandom_range(7) == 0);
      flush_ifu     = ($urandom_range(31) == 0);
      redirect_addr = $urandom & 32'hFFFF_FFFC;
    end
    step();
    flush_ifu = 1'b0;
    stall_dec = 1'b0;
    dec_ready = 1'b1;
  endtask

  task automatic wait_head(input string name);
    bit seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (ifu_inst_p.i1_valid) seen = 1;
    end
    chk({name, "_timeout"}, {63'd0, seen}, 64'd1);
  endtask

  initial begin
    model_restart(RESET_ADDR);
    repeat (2) @(negedge clk);
    chk("rst_req", {63'd0, imem_req}, 64'd0);
    chk("rst_valids", {62'd0, ifu_inst_p.i0_valid, ifu_inst_p.i1_valid}, 64'd0);
    dec_ready = 1'b1;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_req", {63'd0, imem_req}, 64'd1);
    chk("first_req_addr", {32'd0, imem_addr}, {32'd0, RESET_ADDR});
    chk("lat_c0_empty", {63'd0, ifu_inst_p.i1_valid}, 64'd0);
    @(negedge clk);
    chk("lat_c1_empty", {63'd0, ifu_inst_p.i1_valid}, 64'd0);
    @(negedge clk);
    chk("lat_c2_valid", {62'd0, ifu_inst_p.i0_valid, ifu_inst_p.i1_valid}, 64'd3);
    chk("lat_c2_addr", {32'd0, ifu_inst_p.addr}, {32'd0, RESET_ADDR});
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stream_valid", {62'd0, ifu_inst_p.i0_valid, ifu_inst_p.i1_valid}, 64'd3);
    end

    hold_phase(1'b1, 1'b1, "stall");
    repeat (4) step();
    hold_phase(1'b0, 1'b0, "notready");
    repeat (4) step();

    flush_to(32'h0000_0104);
    @(negedge clk);
    chk("redir_req_addr", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'h0000_0100});
    wait_head("redir_head");
    chk("redir_head_addr", {32'd0, ifu_inst_p.addr}, 64'h100);
    chk("redir_head_valids", {62'd0, ifu_inst_p.i0_valid, ifu_inst_p.i1_valid}, 64'd1);
    repeat (6) step();

    flush_to(32'hFFFF_FFF0);
    repeat (8) step();

    random_run(2000);
    repeat (6) step();

    dec_ready = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_req", {63'd0, imem_req}, 64'd0);
    chk("midrst_valids", {62'd0, ifu_inst_p.i0_valid, ifu_inst_p.i1_valid}, 64'd0);
    model_restart(RESET_ADDR);
    repeat (2) step();
    force_stray = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req_addr", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, RESET_ADDR});
    chk("post_rst_empty", {63'd0, ifu_inst_p.i1_valid}, 64'd0);
    repeat (6) step();

    random_run(500);
    repeat (20) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
